// File: rtl/out_port_monitor.sv
// Output-port monitor: queues every value the core writes to OUT for a valid/ready host
// and measures cycles/instructions of a run that ends when OUT hits a target value.
module out_port_monitor #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     out_wr,
  input  logic [WIDTH-1:0]         out_data,
  input  logic                     instr_ret,
  input  logic                     run,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         target,
  output logic                     host_valid,
  output logic [WIDTH-1:0]         host_data,
  input  logic                     host_ready,
  output logic                     done,
  output logic                     overflow,
  output logic [CW-1:0]            cycles,
  output logic [CW-1:0]            instrs,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0]   CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [WIDTH-1:0]  host_data_q, host_data_d;
  logic              host_valid_q, host_valid_d;
  logic              overflow_q, overflow_d;
  logic [CW-1:0]     cycles_q, cycles_d;
  logic [CW-1:0]     instrs_q, instrs_d;

  logic              fifo_empty, fifo_full;
  logic              pop, push;
  logic              match;
  logic              cnt_run, cnt_zero;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign pop        = !clear && !fifo_empty && host_ready;
  assign push       = !clear && out_wr && (!fifo_full || pop);
  assign match      = out_wr && (out_data == target);

  // FSM state register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; clear overrides every transition
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (run)   state_d = RUN;
        RUN:     if (match) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    done     = 1'b0;
    cnt_run  = 1'b0;
    cnt_zero = 1'b0;
    case (state_q)
      IDLE:    cnt_zero = 1'b1;
      RUN:     cnt_run  = 1'b1;
      DONE:    done     = 1'b1;
      default: cnt_zero = 1'b1;
    endcase
  end

  // Saturating measurement counters; the match cycle itself is still counted
  always_comb begin
    cycles_d = cycles_q;
    instrs_d = instrs_q;
    if (clear || cnt_zero) begin
      cycles_d = '0;
      instrs_d = '0;
    end else if (cnt_run) begin
      if (cycles_q != CNT_MAX) begin
        cycles_d = cycles_q + 1'b1;
      end
      if (instr_ret && (instrs_q != CNT_MAX)) begin
        instrs_d = instrs_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // The next head may be the word being written this cycle, so bypass it from out_data
  always_comb begin
    host_data_d  = host_data_q;
    host_valid_d = (count_d != '0);
    if (!clear && (count_d != '0)) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        host_data_d = out_data;
      end else begin
        host_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else if (out_wr && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= out_data;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      host_data_q  <= '0;
      host_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      cycles_q     <= '0;
      instrs_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      host_data_q  <= host_data_d;
      host_valid_q <= host_valid_d;
      overflow_q   <= overflow_d;
      cycles_q     <= cycles_d;
      instrs_q     <= instrs_d;
    end
  end

  assign host_valid = host_valid_q;
  assign host_data  = host_data_q;
  assign overflow   = overflow_q;
  assign cycles     = cycles_q;
  assign instrs     = instrs_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_out_port_monitor.sv
// Bench for out_port_monitor: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_out_port_monitor;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 6;
  localparam int MAXC  = (1 << CW) - 1;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic             out_wr = 1'b0;
  logic [WIDTH-1:0] out_data = '0;
  logic             instr_ret = 1'b0;
  logic             run = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] target = '0;
  logic             host_ready = 1'b0;
  logic             host_valid;
  logic [WIDTH-1:0] host_data;
  logic             done;
  logic             overflow;
  logic [CW-1:0]    cycles;
  logic [CW-1:0]    instrs;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;
  bit chkEn  = 1'b0;

  // Behavioural model: a queue for the FIFO, two flags for the run phase
  logic [WIDTH-1:0] mQ[$];
  logic [WIDTH-1:0] mHead = '0;
  bit               mRunning = 1'b0;
  bit               mDone = 1'b0;
  bit               mOvf = 1'b0;
  int               mCyc = 0;
  int               mIns = 0;

  out_port_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .reset(reset), .out_wr(out_wr), .out_data(out_data),
    .instr_ret(instr_ret), .run(run), .clear(clear), .target(target),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .done(done), .overflow(overflow), .cycles(cycles), .instrs(instrs),
    .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [WIDTH-1:0] data, input logic ret,
                               input logic rn, input logic clr, input logic rdy);
    out_wr     = wr;
    out_data   = data;
    instr_ret  = ret;
    run        = rn;
    clear      = clr;
    host_ready = rdy;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    logic [WIDTH-1:0] popped;
    bit popNow, wasFull;
    forever begin
      @(posedge CLK or negedge reset);
      if (!reset) begin
        mQ.delete();
        mHead = '0; mRunning = 0; mDone = 0; mOvf = 0; mCyc = 0; mIns = 0;
      end else if (clear) begin
        mQ.delete();
        mRunning = 0; mDone = 0; mOvf = 0; mCyc = 0; mIns = 0;
      end else begin
        popNow  = (mQ.size() > 0) && host_ready;
        wasFull = (mQ.size() == DEPTH);
        if (popNow) popped = mQ.pop_front();
        if (out_wr) begin
          if (!wasFull || popNow) mQ.push_back(out_data);
          else mOvf = 1;
        end
        if (mRunning) begin
          if (mCyc < MAXC) mCyc++;
          if (instr_ret && mIns < MAXC) mIns++;
          if (out_wr && out_data == target) begin
            mRunning = 0;
            mDone = 1;
          end
        end else if (!mDone && run) begin
          mRunning = 1;
        end
        if (mQ.size() > 0) mHead = mQ[0];
      end
    end
  end

  always @(negedge CLK) begin
    if (chkEn) begin
      checkOutput("host_valid", 32'(host_valid), 32'(mQ.size() != 0));
      checkOutput("host_data", 32'(host_data), 32'(mHead));
      checkOutput("done", 32'(done), 32'(mDone));
      checkOutput("overflow", 32'(overflow), 32'(mOvf));
      checkOutput("cycles", 32'(cycles), 32'(mCyc));
      checkOutput("instrs", 32'(instrs), 32'(mIns));
      checkOutput("fifo_count", 32'(fifo_count), 32'(mQ.size()));
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(host_valid), 0);
    checkOutput({tag, "_data"}, 32'(host_data), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_ovf"}, 32'(overflow), 0);
    checkOutput({tag, "_cycles"}, 32'(cycles), 0);
    checkOutput({tag, "_instrs"}, 32'(instrs), 0);
    checkOutput({tag, "_count"}, 32'(fifo_count), 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    checkAllZero("reset");
    reset = 1'b1;
    chkEn = 1'b1;

    // Run to a target of 11 with 10 retirements, match on the 12th run cycle
    target = 16'd11;
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int c = 1; c <= 12; c++) applyStimulus(c == 12, 16'd11, c <= 10, 1, 0, 0);
    checkOutput("t1_done", 32'(done), 1);
    checkOutput("t1_cycles", 32'(cycles), 12);
    checkOutput("t1_instrs", 32'(instrs), 10);
    checkOutput("t1_valid", 32'(host_valid), 1);
    checkOutput("t1_data", 32'(host_data), 11);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("t1_frozen", 32'(cycles), 12);

    // Clear out of DONE, then a new run with non-matching writes before the target
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("t4_done", 32'(done), 0);
    checkOutput("t4_cycles", 32'(cycles), 0);
    checkOutput("t4_instrs", 32'(instrs), 0);
    checkOutput("t4_count", 32'(fifo_count), 0);
    target = 16'd13;
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 16'd10, 1, 0, 0, 0);
    applyStimulus(1, 16'd12, 0, 0, 0, 0);
    checkOutput("t6_done", 32'(done), 0);
    checkOutput("t6_count", 32'(fifo_count), 2);
    checkOutput("t6_head", 32'(host_data), 10);
    checkOutput("t6_cycles", 32'(cycles), 2);
    applyStimulus(1, 16'd13, 1, 0, 0, 0);
    checkOutput("t4_done2", 32'(done), 1);
    checkOutput("t4_cycles2", 32'(cycles), 3);
    checkOutput("t4_instrs2", 32'(instrs), 2);

    // Overflow: five writes into a four-entry FIFO, then drain in order
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) applyStimulus(1, 16'(i), 0, 0, 0, 0);
    checkOutput("t2_count", 32'(fifo_count), 4);
    checkOutput("t2_ovf", 32'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("t2_order", 32'(host_data), 32'(i));
      applyStimulus(0, 0, 0, 0, 0, 1);
    end
    checkOutput("t2_empty", 32'(host_valid), 0);
    checkOutput("t2_hold", 32'(host_data), 4);

    // Full FIFO with simultaneous pop and push
    applyStimulus(0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(1, 16'(i), 0, 0, 0, 0);
    applyStimulus(1, 16'd9, 0, 0, 0, 1);
    checkOutput("t3_count", 32'(fifo_count), 4);
    checkOutput("t3_ovf", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_order", 32'(host_data), (i == 3) ? 9 : 32'(i + 2));
      applyStimulus(0, 0, 0, 0, 0, 1);
    end

    // Asynchronous reset in the middle of a run
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(i < 3, 16'(i + 20), 1, 0, 0, 0);
    checkOutput("t5_cycles", 32'(cycles), 7);
    #2 reset = 1'b0;
    #1 checkAllZero("t5");
    @(negedge CLK);
    reset = 1'b1;

    // Counter saturation
    target = 16'hFFFF;
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 70; i++) applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("sat_cycles", 32'(cycles), MAXC);
    checkOutput("sat_instrs", 32'(instrs), MAXC);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) target = 16'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 49) == 0,
                    (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0));
    end

    chkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
